// File: rtl/inversemap_ram_arbiter.sv
// Arbiter sharing the 256x60 inversemap table RAM port between the config
// (read/write) and frame lookup (read) paths; read data is routed back by tag.
module inversemap_ram_arbiter #(
  parameter int unsigned RAM_RD_LAT   = 2,
  parameter int unsigned CFG_MAX_WAIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lkp_req,
  input  logic [7:0]  iv_lkp_addr,
  output logic        o_lkp_ack,
  output logic        o_lkp_rdata_valid,
  output logic [59:0] ov_lkp_rdata,
  input  logic        i_cfg_req,
  input  logic        i_cfg_wr,
  input  logic [7:0]  iv_cfg_addr,
  input  logic [59:0] iv_cfg_wdata,
  output logic        o_cfg_ack,
  output logic        o_cfg_rdata_valid,
  output logic [59:0] ov_cfg_rdata,
  output logic [7:0]  ov_ram_addr,
  output logic [59:0] ov_ram_wdata,
  output logic        o_ram_wr,
  output logic        o_ram_rd,
  input  logic [59:0] iv_ram_rdata
);

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 60;
  localparam int unsigned WCW = 8;
  localparam logic OWN_LKP = 1'b0;
  localparam logic OWN_CFG = 1'b1;

  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                  force_c, cfg_gnt_c, lkp_gnt_c;
  logic [AW-1:0]         ram_addr_q, ram_addr_d;
  logic [DW-1:0]         ram_wdata_q, ram_wdata_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  ram_rd_q, ram_rd_d;
  logic [RAM_RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RAM_RD_LAT-1:0] tag_own_q, tag_own_d;
  logic                  lkp_rv_q, lkp_rv_d;
  logic                  cfg_rv_q, cfg_rv_d;
  logic [DW-1:0]         lkp_rdata_q, lkp_rdata_d;
  logic [DW-1:0]         cfg_rdata_q, cfg_rdata_d;

  // Lookup wins unless config has been starved for CFG_MAX_WAIT cycles.
  always_comb begin
    force_c   = (wait_cnt_q == WCW'(CFG_MAX_WAIT));
    cfg_gnt_c = i_cfg_req && (force_c || !i_lkp_req);
    lkp_gnt_c = i_lkp_req && !cfg_gnt_c;
  end

  assign o_lkp_ack = lkp_gnt_c;
  assign o_cfg_ack = cfg_gnt_c;

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wr_d    = 1'b0;
    ram_rd_d    = 1'b0;
    tag_vld_d   = tag_vld_q;
    tag_own_d   = tag_own_q;
    lkp_rdata_d = lkp_rdata_q;
    cfg_rdata_d = cfg_rdata_q;

    if (!i_cfg_req || cfg_gnt_c) begin
      wait_cnt_d = '0;
    end else if (!force_c) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    if (cfg_gnt_c) begin
      ram_addr_d = iv_cfg_addr;
      if (i_cfg_wr) begin
        ram_wr_d    = 1'b1;
        ram_wdata_d = iv_cfg_wdata;
      end else begin
        ram_rd_d = 1'b1;
      end
    end else if (lkp_gnt_c) begin
      ram_addr_d = iv_lkp_addr;
      ram_rd_d   = 1'b1;
    end

    // Tags enter at grant time; writes travel as empty slots to keep alignment.
    tag_vld_d[0] = lkp_gnt_c || (cfg_gnt_c && !i_cfg_wr);
    tag_own_d[0] = cfg_gnt_c ? OWN_CFG : OWN_LKP;
    for (int i = 1; i < int'(RAM_RD_LAT); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end

    lkp_rv_d = tag_vld_q[RAM_RD_LAT-1] && (tag_own_q[RAM_RD_LAT-1] == OWN_LKP);
    cfg_rv_d = tag_vld_q[RAM_RD_LAT-1] && (tag_own_q[RAM_RD_LAT-1] == OWN_CFG);
    if (lkp_rv_d) lkp_rdata_d = iv_ram_rdata;
    if (cfg_rv_d) cfg_rdata_d = iv_ram_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wr_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      lkp_rv_q    <= 1'b0;
      cfg_rv_q    <= 1'b0;
      lkp_rdata_q <= '0;
      cfg_rdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wr_q    <= ram_wr_d;
      ram_rd_q    <= ram_rd_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      lkp_rv_q    <= lkp_rv_d;
      cfg_rv_q    <= cfg_rv_d;
      lkp_rdata_q <= lkp_rdata_d;
      cfg_rdata_q <= cfg_rdata_d;
    end
  end

  assign ov_ram_addr       = ram_addr_q;
  assign ov_ram_wdata      = ram_wdata_q;
  assign o_ram_wr          = ram_wr_q;
  assign o_ram_rd          = ram_rd_q;
  assign o_lkp_rdata_valid = lkp_rv_q;
  assign ov_lkp_rdata      = lkp_rdata_q;
  assign o_cfg_rdata_valid = cfg_rv_q;
  assign ov_cfg_rdata      = cfg_rdata_q;

endmodule

// File: tb/tb_inversemap_ram_arbiter.sv
// Self-checking bench for inversemap_ram_arbiter: vector table, directed
// corner sequences and randomized traffic against a queue-based reference.
module tb_inversemap_ram_arbiter;

  localparam int LAT  = 2;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lkp_req, cfg_req, cfg_wr;
  logic [7:0]  lkp_addr, cfg_addr;
  logic [59:0] cfg_wdata;
  logic        lkp_ack, cfg_ack, lkp_rv, cfg_rv, ram_wr, ram_rd;
  logic [59:0] lkp_rdata, cfg_rdata, ram_wdata, ram_q;
  logic [7:0]  ram_addr;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [59:0] bd_data;
  logic [59:0] ram_mem [256];
  logic [59:0] sh_mem  [256];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { logic [59:0] data; int due; } exp_t;
  exp_t lq[$];
  exp_t cq[$];
  int   mw = 0;
  logic p_rd = 1'b0, p_wr = 1'b0;
  logic [7:0]  p_addr = '0;
  logic [59:0] p_wdata = '0;

  always #5 clk = ~clk;

  inversemap_ram_arbiter #(.RAM_RD_LAT(LAT), .CFG_MAX_WAIT(MAXW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lkp_req(lkp_req), .iv_lkp_addr(lkp_addr), .o_lkp_ack(lkp_ack),
    .o_lkp_rdata_valid(lkp_rv), .ov_lkp_rdata(lkp_rdata),
    .i_cfg_req(cfg_req), .i_cfg_wr(cfg_wr), .iv_cfg_addr(cfg_addr),
    .iv_cfg_wdata(cfg_wdata), .o_cfg_ack(cfg_ack),
    .o_cfg_rdata_valid(cfg_rv), .ov_cfg_rdata(cfg_rdata),
    .ov_ram_addr(ram_addr), .ov_ram_wdata(ram_wdata),
    .o_ram_wr(ram_wr), .o_ram_rd(ram_rd), .iv_ram_rdata(ram_q)
  );

  // Table RAM: q appears the cycle after the read command, sampled by the DUT one cycle later.
  always @(posedge clk) begin
    if (bd_we) ram_mem[bd_addr] <= bd_data;
    else if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_q <= ram_mem[ram_addr];
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    lkp_req = 1'b0; cfg_req = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [59:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    sh_mem[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_lkp_ack"}, lkp_ack, 1'b0);
    chk1({tag, "_cfg_ack"}, cfg_ack, 1'b0);
    chk1({tag, "_lkp_rv"}, lkp_rv, 1'b0);
    chk1({tag, "_cfg_rv"}, cfg_rv, 1'b0);
    chk1({tag, "_ram_wr"}, ram_wr, 1'b0);
    chk1({tag, "_ram_rd"}, ram_rd, 1'b0);
    chkw({tag, "_ram_addr"}, 64'(ram_addr), 64'(0));
    chkw({tag, "_ram_wdata"}, 64'(ram_wdata), 64'(0));
    chkw({tag, "_lkp_rdata"}, 64'(lkp_rdata), 64'(0));
    chkw({tag, "_cfg_rdata"}, 64'(cfg_rdata), 64'(0));
  endtask

  // Reference: grant by priority/starvation rule, shadow memory updated in grant order,
  // per-requester queues of expected read data with their due cycle.
  task automatic model_cycle();
    logic ev, ecfg, elkp, frc;
    ev = (lq.size() > 0) && (lq[0].due == cyc);
    chk1("rnd_lkp_valid", lkp_rv, ev);
    if (ev) begin
      chkw("rnd_lkp_rdata", 64'(lkp_rdata), 64'(lq[0].data));
      void'(lq.pop_front());
    end
    ev = (cq.size() > 0) && (cq[0].due == cyc);
    chk1("rnd_cfg_valid", cfg_rv, ev);
    if (ev) begin
      chkw("rnd_cfg_rdata", 64'(cfg_rdata), 64'(cq[0].data));
      void'(cq.pop_front());
    end
    chk1("rnd_ram_rd", ram_rd, p_rd);
    chk1("rnd_ram_wr", ram_wr, p_wr);
    if (p_rd || p_wr) chkw("rnd_ram_addr", 64'(ram_addr), 64'(p_addr));
    if (p_wr) chkw("rnd_ram_wdata", 64'(ram_wdata), 64'(p_wdata));
    frc  = (mw == MAXW);
    ecfg = cfg_req && (frc || !lkp_req);
    elkp = lkp_req && !ecfg;
    chk1("rnd_cfg_ack", cfg_ack, ecfg);
    chk1("rnd_lkp_ack", lkp_ack, elkp);
    p_rd = elkp || (ecfg && !cfg_wr);
    p_wr = ecfg && cfg_wr;
    if (ecfg) begin
      p_addr = cfg_addr;
      if (cfg_wr) begin
        p_wdata = cfg_wdata;
        sh_mem[cfg_addr] = cfg_wdata;
      end else begin
        cq.push_back('{sh_mem[cfg_addr], cyc + 1 + LAT});
      end
    end else if (elkp) begin
      p_addr = lkp_addr;
      lq.push_back('{sh_mem[lkp_addr], cyc + 1 + LAT});
    end
    if (!cfg_req || ecfg) mw = 0;
    else if (mw < MAXW) mw++;
  endtask

  typedef struct {
    logic lkp; logic cfg; logic wr;
    logic exp_lack; logic exp_cack; logic exp_rd; logic exp_wr;
  } vec_t;

  initial begin
    vec_t        vt [6];
    logic [7:0]  la, ca, ea;
    logic [59:0] wd;
    logic [63:0] r64;
    logic        l_acked, c_acked;
    int          lkp_pct;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    lkp_addr = '0; cfg_addr = '0; cfg_wdata = '0;
    idle();
    sample();
    check_zero("reset");
    for (int i = 0; i < 256; i++) begin
      r64 = {$urandom, $urandom};
      bd_write(8'(i), 60'(r64));
    end
    sample();
    check_zero("reset_held");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single-cycle arbitration vectors, each followed by an idle cycle.
    for (int i = 0; i < 6; i++) begin
      tick();
      la = 8'(i * 17 + 3); ca = 8'(i * 29 + 100);
      wd = 60'(64'h0F00_0000_0000_0000 + 64'(i));
      lkp_req = vt[i].lkp; cfg_req = vt[i].cfg; cfg_wr = vt[i].wr;
      lkp_addr = la; cfg_addr = ca; cfg_wdata = wd;
      sample();
      chk1("tbl_lkp_ack", lkp_ack, vt[i].exp_lack);
      chk1("tbl_cfg_ack", cfg_ack, vt[i].exp_cack);
      if (vt[i].exp_cack && vt[i].wr) sh_mem[ca] = wd;
      ea = vt[i].exp_cack ? ca : la;
      tick();
      idle();
      sample();
      chk1("tbl_ram_rd", ram_rd, vt[i].exp_rd);
      chk1("tbl_ram_wr", ram_wr, vt[i].exp_wr);
      if (vt[i].exp_rd || vt[i].exp_wr) chkw("tbl_ram_addr", 64'(ram_addr), 64'(ea));
      if (vt[i].exp_wr) chkw("tbl_ram_wdata", 64'(ram_wdata), 64'(wd));
    end
    repeat (5) tick();

    // Lone lookup read.
    bd_write(8'h05, 60'h0AB_CDEF_0123_4567);
    tick();
    lkp_req = 1'b1; lkp_addr = 8'h05;
    sample();
    chk1("t1_lkp_ack", lkp_ack, 1'b1);
    chk1("t1_cfg_ack", cfg_ack, 1'b0);
    tick();
    idle();
    sample();
    chk1("t1_ram_rd", ram_rd, 1'b1);
    chk1("t1_ram_wr", ram_wr, 1'b0);
    chkw("t1_ram_addr", 64'(ram_addr), 64'h05);
    tick();
    sample();
    chk1("t1_lkp_rv_early", lkp_rv, 1'b0);
    tick();
    sample();
    chk1("t1_lkp_rv", lkp_rv, 1'b1);
    chkw("t1_lkp_rdata", 64'(lkp_rdata), 64'h0AB_CDEF_0123_4567);
    chk1("t1_cfg_rv", cfg_rv, 1'b0);
    tick();
    sample();
    chk1("t1_lkp_rv_pulse", lkp_rv, 1'b0);

    // Config write then lookup read of the same address.
    tick();
    cfg_req = 1'b1; cfg_wr = 1'b1; cfg_addr = 8'h10; cfg_wdata = 60'h123456789ABCDEF;
    sample();
    chk1("t2_cfg_ack", cfg_ack, 1'b1);
    sh_mem[8'h10] = 60'h123456789ABCDEF;
    tick();
    idle();
    lkp_req = 1'b1; lkp_addr = 8'h10;
    sample();
    chk1("t2_lkp_ack", lkp_ack, 1'b1);
    chk1("t2_ram_wr", ram_wr, 1'b1);
    chkw("t2_ram_wdata", 64'(ram_wdata), 64'h123456789ABCDEF);
    tick();
    idle();
    sample();
    chk1("t2_ram_rd", ram_rd, 1'b1);
    chk1("t2_ram_wr_off", ram_wr, 1'b0);
    repeat (2) tick();
    sample();
    chk1("t2_lkp_rv", lkp_rv, 1'b1);
    chkw("t2_lkp_rdata", 64'(lkp_rdata), 64'h123456789ABCDEF);

    // Starvation bound: config forced through after CFG_MAX_WAIT denials.
    repeat (3) tick();
    for (int c = 0; c <= MAXW; c++) begin
      tick();
      if (c == 0) begin
        lkp_req = 1'b1; lkp_addr = 8'h22;
        cfg_req = 1'b1; cfg_wr = 1'b0; cfg_addr = 8'h33;
      end
      sample();
      chk1("t3_cfg_ack", cfg_ack, c == MAXW);
      chk1("t3_lkp_ack", lkp_ack, c != MAXW);
    end
    tick();
    cfg_req = 1'b0;
    sample();
    chk1("t3_lkp_reack", lkp_ack, 1'b1);
    chk1("t3_cfg_ack_off", cfg_ack, 1'b0);
    tick();
    idle();
    repeat (6) tick();

    // Reset while a lookup read is in flight.
    lkp_req = 1'b1; lkp_addr = 8'h07;
    sample();
    chk1("t5_lkp_ack", lkp_ack, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    sample();
    check_zero("t5_rst1");
    tick();
    sample();
    check_zero("t5_rst2");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk1("t5_no_lkp_rv", lkp_rv, 1'b0);
      tick();
    end

    // Both idle: no RAM activity.
    for (int c = 0; c < 3; c++) begin
      tick();
      sample();
      chk1("idle_ram_rd", ram_rd, 1'b0);
      chk1("idle_ram_wr", ram_wr, 1'b0);
    end

    // Randomized traffic against the reference model.
    l_acked = 1'b0; c_acked = 1'b0;
    p_rd = 1'b0; p_wr = 1'b0; mw = 0;
    for (int k = 0; k < 700; k++) begin
      tick();
      lkp_pct = (k < 250) ? 95 : 50;
      if (l_acked || !lkp_req) begin
        lkp_req = ($urandom_range(0, 99) < lkp_pct);
        lkp_addr = 8'($urandom_range(0, 31));
      end else if ($urandom_range(0, 99) < 4) begin
        lkp_req = 1'b0;
      end
      if (c_acked || !cfg_req) begin
        cfg_req = ($urandom_range(0, 99) < 40);
        cfg_wr = 1'($urandom_range(0, 1));
        cfg_addr = 8'($urandom_range(0, 31));
        r64 = {$urandom, $urandom};
        cfg_wdata = 60'(r64);
      end
      sample();
      l_acked = lkp_req && lkp_ack;
      c_acked = cfg_req && cfg_ack;
      model_cycle();
    end
    tick();
    idle();
    for (int k = 0; k < LAT + 4; k++) begin
      sample();
      model_cycle();
      tick();
    end
    chkw("rnd_lkp_drained", 64'(lq.size()), 64'(0));
    chkw("rnd_cfg_drained", 64'(cq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
